// File: rtl/pwm_pkg.sv
// pwm_pkg: shared duty width and fader state encoding
package pwm_pkg;
  localparam int DUTY_W = 8;
  typedef enum logic [2:0] {IDLE, RAMP, BR_UP, BR_HOLD_HI, BR_DOWN, BR_HOLD_LO} fader_state_t;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: one-cycle tick every DIV enabled cycles; counter clears while disabled
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(DIV - 1);
  always_ff @(posedge clk)
    if (rst || !en) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/pwm_fader.sv
// pwm_fader: ramps duty_cycle toward accepted targets or breathes 0<->255 on prescaled ticks
module pwm_fader
  import pwm_pkg::*;
#(
  parameter int STEP_DIV   = 100000,
  parameter int STEP_SIZE  = 1,
  parameter int HOLD_STEPS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode_breathe,
  input  logic [DUTY_W-1:0] target,
  input  logic              target_valid,
  output logic              target_ready,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              duty_valid,
  output logic              busy
);
  localparam int HW = $clog2(HOLD_STEPS + 1);
  localparam logic [DUTY_W-1:0] S8 = DUTY_W'(STEP_SIZE);
  localparam logic [DUTY_W:0] S9 = (DUTY_W + 1)'(STEP_SIZE);
  generate
    if (STEP_DIV < 2 || STEP_SIZE < 1 || STEP_SIZE > 255 || HOLD_STEPS < 1) begin : g_bad_params
      $error("pwm_fader: illegal parameters");
    end
  endgenerate
  fader_state_t state, state_n;
  logic [DUTY_W-1:0] tgt_q, tgt_n, duty_n, eff, gap, st;
  logic [DUTY_W:0] inc, dec;
  logic [HW-1:0] hold, hold_n;
  logic tick, follow, accept, valid_n, init_q;
  tick_gen #(.DIV(STEP_DIV)) u_tick (.clk(clk), .rst(rst), .en(enable), .tick(tick));
  assign follow = state == IDLE || state == RAMP;
  assign target_ready = !rst && follow && !mode_breathe;
  assign busy = state != IDLE;
  assign accept = target_valid && target_ready;
  // a target accepted on a tick cycle steers that very step
  assign eff = accept ? target : tgt_q;
  assign gap = eff > duty_cycle ? eff - duty_cycle : duty_cycle - eff;
  assign st = gap < S8 ? gap : S8;
  assign inc = {1'b0, duty_cycle} + S9;
  assign dec = {1'b0, duty_cycle} - S9;
  always_comb begin
    state_n = state;
    duty_n = duty_cycle;
    hold_n = hold;
    valid_n = 1'b0;
    tgt_n = eff;
    if (mode_breathe && follow) state_n = BR_UP;
    else if (!mode_breathe && !follow) begin
      state_n = IDLE;
      hold_n = '0;
    end else
      case (state)
        IDLE: state_n = accept && target != duty_cycle ? RAMP : IDLE;
        RAMP:
          if (eff == duty_cycle) state_n = IDLE;
          else if (tick) begin
            duty_n = eff > duty_cycle ? duty_cycle + st : duty_cycle - st;
            valid_n = 1'b1;
            state_n = duty_n == eff ? IDLE : RAMP;
          end
        BR_UP:
          if (tick) begin
            duty_n = inc[DUTY_W] ? '1 : inc[DUTY_W-1:0];
            valid_n = 1'b1;
            state_n = &duty_n ? BR_HOLD_HI : BR_UP;
          end
        BR_DOWN:
          if (tick) begin
            duty_n = dec[DUTY_W] ? '0 : dec[DUTY_W-1:0];
            valid_n = 1'b1;
            state_n = duty_n == '0 ? BR_HOLD_LO : BR_DOWN;
          end
        BR_HOLD_HI, BR_HOLD_LO:
          if (tick) begin
            hold_n = hold == HW'(HOLD_STEPS - 1) ? '0 : hold + 1'b1;
            state_n = hold != HW'(HOLD_STEPS - 1) ? state : state == BR_HOLD_HI ? BR_DOWN : BR_UP;
          end
        default: state_n = IDLE;
      endcase
  end
  // init_q makes the first post-reset cycle announce duty 0 to the pwm
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      duty_cycle <= '0;
      duty_valid <= 1'b0;
      hold <= '0;
      tgt_q <= '0;
      init_q <= 1'b1;
    end else begin
      state <= state_n;
      duty_cycle <= duty_n;
      duty_valid <= valid_n || init_q;
      hold <= hold_n;
      tgt_q <= tgt_n;
      init_q <= 1'b0;
    end
endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader: directed plus random ramps against an arithmetic duty model; breathe on a second instance
module tb_pwm_fader;
  logic clk = 1'b0, rst = 1'b1;
  logic en_a = 1'b1, mb_a = 1'b0, tv_a = 1'b0, ready_a, dv_a, busy_a;
  logic en_b = 1'b1, mb_b = 1'b0, tv_b = 1'b0, ready_b, dv_b, busy_b;
  logic [7:0] tgt_a = 8'd0, tgt_b = 8'd0, duty_a, duty_b;
  int n_cmp = 0, n_err = 0;
  int cur, t, v1, v2;
  logic any;
  always #5 clk = ~clk;
  pwm_fader #(.STEP_DIV(4), .STEP_SIZE(3), .HOLD_STEPS(2)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .mode_breathe(mb_a), .target(tgt_a),
    .target_valid(tv_a), .target_ready(ready_a), .duty_cycle(duty_a),
    .duty_valid(dv_a), .busy(busy_a));
  pwm_fader #(.STEP_DIV(4), .STEP_SIZE(100), .HOLD_STEPS(2)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .mode_breathe(mb_b), .target(tgt_b),
    .target_valid(tv_b), .target_ready(ready_b), .duty_cycle(duty_b),
    .duty_valid(dv_b), .busy(busy_b));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int next_val(input int v, input int to);
    return to > v ? (v + 3 > to ? to : v + 3) : (v - 3 < to ? to : v - 3);
  endfunction
  // gap > 0: exact cycles since previous sample point; gap < 0: at most -gap cycles
  task automatic expect_pulse(input bit b, input int val, input int gap);
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while (!(b ? dv_b : dv_a) && c < 40);
    check("pulse", {31'd0, b ? dv_b : dv_a}, 1);
    check("duty", {24'd0, b ? duty_b : duty_a}, val);
    if (gap > 0) check("gap", c, gap);
    else check("gap_max", {31'd0, c <= -gap}, 1);
  endtask
  task automatic accept_a(input int v);
    tgt_a = 8'(v);
    tv_a = 1'b1;
    step();
    tv_a = 1'b0;
  endtask
  task automatic run_ramp(input int from, input int to);
    int v;
    bit first;
    v = from;
    first = 1'b1;
    while (v != to) begin
      v = next_val(v, to);
      expect_pulse(1'b0, v, first ? -4 : 4);
      first = 1'b0;
    end
    check("ramp_idle", {31'd0, busy_a}, 0);
  endtask
  initial begin
    repeat (3) begin
      step();
      check("rst_duty", {24'd0, duty_a}, 0);
      check("rst_valid", {31'd0, dv_a}, 0);
      check("rst_busy", {31'd0, busy_a}, 0);
      check("rst_ready", {31'd0, ready_a}, 0);
    end
    rst = 1'b0;
    step();
    check("rel_valid", {31'd0, dv_a}, 1);
    check("rel_duty", {24'd0, duty_a}, 0);
    check("rel_busy", {31'd0, busy_a}, 0);
    check("rel_ready", {31'd0, ready_a}, 1);
    check("rel_valid_b", {31'd0, dv_b}, 1);
    step();
    check("rel_once", {31'd0, dv_a}, 0);
    accept_a(10);
    check("ramp_busy", {31'd0, busy_a}, 1);
    run_ramp(0, 10);
    run_ramp(10, 10);
    accept_a(0);
    run_ramp(10, 0);
    accept_a(200);
    expect_pulse(1'b0, 3, -4);
    expect_pulse(1'b0, 6, 4);
    expect_pulse(1'b0, 9, 4);
    accept_a(5);
    expect_pulse(1'b0, 6, 3);
    expect_pulse(1'b0, 5, 4);
    check("retgt_idle", {31'd0, busy_a}, 0);
    cur = 5;
    repeat (4) begin
      t = $urandom_range(0, 255);
      if (t == cur) t = (t + 128) % 256;
      accept_a(t);
      run_ramp(cur, t);
      cur = t;
    end
    t = cur < 128 ? cur + 90 : cur - 90;
    v1 = next_val(cur, t);
    v2 = next_val(v1, t);
    accept_a(t);
    expect_pulse(1'b0, v1, -4);
    en_a = 1'b0;
    any = 1'b0;
    repeat (20) begin
      step();
      any |= dv_a;
    end
    check("frz_valid", {31'd0, any}, 0);
    check("frz_duty", {24'd0, duty_a}, v1);
    en_a = 1'b1;
    expect_pulse(1'b0, v2, 4);
    run_ramp(v2, t);
    accept_a(t);
    any = 1'b0;
    repeat (8) begin
      step();
      any |= dv_a | busy_a;
    end
    check("same_tgt", {31'd0, any}, 0);
    mb_b = 1'b1;
    #1;
    check("br_ready", {31'd0, ready_b}, 0);
    expect_pulse(1'b1, 100, -5);
    mb_b = 1'b0;
    step();
    check("exit_busy", {31'd0, busy_b}, 0);
    check("exit_duty", {24'd0, duty_b}, 100);
    any = 1'b0;
    repeat (6) begin
      step();
      any |= dv_b;
    end
    check("exit_quiet", {31'd0, any}, 0);
    mb_b = 1'b1;
    expect_pulse(1'b1, 200, -5);
    expect_pulse(1'b1, 255, 4);
    check("br_ready_hi", {31'd0, ready_b}, 0);
    expect_pulse(1'b1, 155, 12);
    expect_pulse(1'b1, 55, 4);
    expect_pulse(1'b1, 0, 4);
    expect_pulse(1'b1, 100, 12);
    expect_pulse(1'b1, 200, 4);
    check("br_busy", {31'd0, busy_b}, 1);
    rst = 1'b1;
    step();
    check("abort_duty", {24'd0, duty_b}, 0);
    check("abort_busy", {31'd0, busy_b}, 0);
    check("abort_valid", {31'd0, dv_b}, 0);
    mb_b = 1'b0;
    step();
    check("abort_quiet", {31'd0, dv_b}, 0);
    rst = 1'b0;
    step();
    check("rel2_valid", {31'd0, dv_b}, 1);
    check("rel2_duty", {24'd0, duty_b}, 0);
    step();
    check("rel2_once", {31'd0, dv_b}, 0);
    check("rel2_idle", {31'd0, busy_b}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pwm_fader.md
PWM_FADER -- requirements
Module: pwm_fader

Interface
REQ-001 SHALL have parameter STEP_DIV, default 100000, meaning clock cycles per ramp step (legal range ≥ 2).
REQ-002 SHALL have parameter STEP_SIZE, default 1, meaning duty increment per step (legal range 1..255).
REQ-003 SHALL have parameter HOLD_STEPS, default 16, meaning steps spent at each breathe extreme (legal range ≥ 1).
REQ-004 clk  input  1  sole clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  high = step timer runs; low = freeze.
REQ-007 mode_breathe  input  1  high = continuous 0↔255 breathing; low = target-follow mode.
REQ-008 target  input  8  requested duty value.
REQ-009 target_valid  input  1  target offered this cycle.
REQ-010 target_ready  output  1  target can be accepted this cycle.
REQ-011 duty_cycle  output  8  current duty, registered; feeds pwm.duty_cycle.
REQ-012 duty_valid  output  1  one-cycle pulse marking a new duty_cycle value; feeds pwm.duty_valid.
REQ-013 busy  output  1  high while the state is anything other than IDLE.

Function
REQ-014 SHALL implement the states IDLE, RAMP, BR_UP, BR_HOLD_HI, BR_DOWN and BR_HOLD_LO.
REQ-015 Prescaler SHALL count 0..STEP_DIV-1 while enable=1 and assert tick for one cycle at STEP_DIV-1, then wrap to 0.
REQ-016 Prescaler SHALL clear to 0 while enable=0, with state and outputs frozen.
REQ-017 target_ready SHALL equal (state ∈ {IDLE, RAMP}) && !mode_breathe.
REQ-018 Acceptance SHALL occur on target_valid && target_ready, storing target in tgt_q.
REQ-019 An accepted target ≠ duty_cycle SHALL move the state to RAMP next cycle; an accepted target = duty_cycle SHALL leave the state at IDLE with no duty_valid.
REQ-020 An accept during RAMP SHALL replace tgt_q without resetting the prescaler, and the ramp direction SHALL follow the new tgt_q.
REQ-021 On tick in RAMP, duty_cycle SHALL move toward tgt_q by min(STEP_SIZE, |tgt_q-duty_cycle|), never overshooting, and duty_valid SHALL be 1 on the same cycle the new value appears.
REQ-022 In RAMP, when the updated duty_cycle = tgt_q the state SHALL go to IDLE.
REQ-023 mode_breathe=1 sampled in IDLE or RAMP SHALL transition to BR_UP, starting from the current duty_cycle.
REQ-024 In BR_UP, each tick SHALL add STEP_SIZE saturating at 255, with a duty_valid pulse; on reaching 255 the state SHALL go to BR_HOLD_HI.
REQ-025 BR_HOLD_HI SHALL count HOLD_STEPS ticks with no duty_valid, then go to BR_DOWN.
REQ-026 BR_DOWN SHALL mirror BR_UP, subtracting STEP_SIZE saturating at 0, then go to BR_HOLD_LO; BR_HOLD_LO SHALL then go to BR_UP.
REQ-027 mode_breathe=0 in any BR_* state SHALL transition to IDLE on the next cycle, with duty_cycle held and the hold counter cleared.
REQ-028 When tick and an acceptance coincide in RAMP, the step SHALL use the newly accepted target.
REQ-029 duty_valid SHALL pulse at most once per STEP_DIV cycles, except for the reset-release pulse (REQ-031).
REQ-030 All arithmetic SHALL be 9-bit internally to detect saturation; no 8-bit wrap-around SHALL ever appear on duty_cycle.

Reset
REQ-031 While rst=1: state=IDLE, duty_cycle=0, duty_valid=0, busy=0, prescaler=0, hold count=0, tgt_q=0; target_ready SHALL be 0 while rst=1. On the first cycle after rst falls, duty_valid SHALL pulse once with duty_cycle=0 so that pwm loads a known value.
REQ-032 rst asserted mid-ramp or mid-breathe SHALL abort immediately with no further duty_valid until the post-reset pulse.

Structure
REQ-033 Shared package pwm_pkg SHALL hold the fader_state_t enum and localparam DUTY_W=8.
REQ-034 The prescaler SHALL be the one sub-module, tick_gen (parameter DIV; ports clk, rst, en, tick), reusable by pwm.
REQ-035 Parameters SHALL be checked at elaboration: STEP_DIV ≥ 2, 1 ≤ STEP_SIZE ≤ 255, HOLD_STEPS ≥ 1.

Verification (STEP_DIV=4, STEP_SIZE=3, HOLD_STEPS=2 unless stated)
REQ-036 Reset release: duty_valid pulse with duty=0 one cycle after rst falls; busy=0, target_ready=1.
REQ-037 Accept target=10 from 0: duty sequence 3,6,9,10 with duty_valid every 4 cycles; IDLE after 10; no overshoot.
REQ-038 Retarget: at duty=9 heading to 200, accept target=5: the next steps are 6 then 5; the prescaler phase is unchanged.
REQ-039 Breathe with STEP_SIZE=100: duty 100,200,255, then 2 silent ticks, then 155,55,0, then 2 silent ticks, then 100; target_ready=0 throughout.
REQ-040 enable=0 for 20 cycles mid-ramp: no duty_valid and duty held; when enable returns, the next step occurs after a full 4 cycles.
REQ-041 rst mid-breathe at duty=200: duty=0 next cycle and state IDLE; the single post-release pulse is observed.
